// File: rtl/cpu_seq_pkg.sv
// rtl/cpu_seq_pkg.sv - FSM states, fetch-op codes and reset defaults shared by cpu_sequencer
package cpu_seq_pkg;

  localparam int ADDR_W = 10;
  localparam logic [ADDR_W-1:0] DEFAULT_RESET_PC = 10'd0;

  typedef enum logic [2:0] {
    FETCH  = 3'd0,
    DECODE = 3'd1,
    EXEC   = 3'd2,
    MEM    = 3'd3,
    WB     = 3'd4,
    HALT   = 3'd5
  } state_t;

  localparam logic [1:0] FOP_NEXT   = 2'd0;
  localparam logic [1:0] FOP_BRANCH = 2'd1;
  localparam logic [1:0] FOP_JR     = 2'd2;
  localparam logic [1:0] FOP_HALT   = 2'd3;

endpackage

// File: rtl/pc_next_unit.sv
// rtl/pc_next_unit.sv - combinational next-PC selection; all arithmetic wraps modulo 1024
module pc_next_unit
  import cpu_seq_pkg::*;
(
  input  logic [ADDR_W-1:0] pc,
  input  logic [1:0]        cu_fetch_op,
  input  logic [ADDR_W-1:0] jmp_addr,
  input  logic              branch_take,
  input  logic [ADDR_W-1:0] reg_target,
  output logic [ADDR_W-1:0] next_pc
);

  logic [ADDR_W-1:0] pc_inc;

  assign pc_inc = pc + 10'd1;

  always_comb begin
    next_pc = pc_inc;
    case (cu_fetch_op)
      FOP_NEXT:   next_pc = pc_inc;
      // jmp_addr is already sign-extended, so a plain 10-bit add gives the wrapped offset
      FOP_BRANCH: next_pc = branch_take ? (pc + jmp_addr) : pc_inc;
      FOP_JR:     next_pc = reg_target;
      FOP_HALT:   next_pc = pc;
    endcase
  end

endmodule

// File: rtl/cpu_sequencer.sv
// rtl/cpu_sequencer.sv - multi-cycle fetch/decode/exec/mem/wb sequencer with shared memory port
// Optional CPU_SEQ_SINGLE_STEP_EN adds a step input that gates each instruction fetch.
module cpu_sequencer
  import cpu_seq_pkg::*;
#(
  parameter logic [9:0] RESET_PC = DEFAULT_RESET_PC,
  parameter int          AW       = ADDR_W
) (
  input  logic          clk,
  input  logic          rst,
`ifdef CPU_SEQ_SINGLE_STEP_EN
  input  logic          step,
`endif
  output logic          mem_req,
  input  logic          mem_ack,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  input  logic [AW-1:0] mem_rdata,
  output logic [AW-1:0] ir,
  input  logic [1:0]    cu_fetch_op,
  input  logic          cu_wr_en,
  input  logic          cu_ldst_en,
  input  logic          cu_done,
  input  logic [AW-1:0] jmp_addr,
  input  logic          branch_take,
  input  logic [AW-1:0] reg_target,
  input  logic [AW-1:0] ldst_addr,
  output logic          rf_we,
  output logic [AW-1:0] pc,
  output logic          halted
);

  state_t        state, state_n;
  logic [AW-1:0] pc_n, ir_n, mem_addr_n, next_pc;
  logic          mem_req_n, mem_we_n, rf_we_n, halted_n;
  logic          fetch_go;

`ifdef CPU_SEQ_SINGLE_STEP_EN
  assign fetch_go = step;
`else
  assign fetch_go = 1'b1;
`endif

  pc_next_unit u_pc_next (
    .pc          (pc),
    .cu_fetch_op (cu_fetch_op),
    .jmp_addr    (jmp_addr),
    .branch_take (branch_take),
    .reg_target  (reg_target),
    .next_pc     (next_pc)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= FETCH;
      pc       <= RESET_PC;
      ir       <= '0;
      mem_req  <= 1'b0;
      mem_we   <= 1'b0;
      mem_addr <= '0;
      rf_we    <= 1'b0;
      halted   <= 1'b0;
    end else begin
      state    <= state_n;
      pc       <= pc_n;
      ir       <= ir_n;
      mem_req  <= mem_req_n;
      mem_we   <= mem_we_n;
      mem_addr <= mem_addr_n;
      rf_we    <= rf_we_n;
      halted   <= halted_n;
    end
  end

  always_comb begin
    state_n    = state;
    pc_n       = pc;
    ir_n       = ir;
    mem_req_n  = mem_req;
    mem_we_n   = mem_we;
    mem_addr_n = mem_addr;
    rf_we_n    = 1'b0;
    halted_n   = halted;
    case (state)
      FETCH: begin
        // acks are only honoured once our own request is visible on the port
        if (!mem_req) begin
          if (fetch_go) begin
            mem_req_n  = 1'b1;
            mem_we_n   = 1'b0;
            mem_addr_n = pc;
          end
        end else if (mem_ack) begin
          ir_n      = mem_rdata;
          mem_req_n = 1'b0;
          state_n   = DECODE;
        end
      end
      DECODE: begin
        // registered strobe lands exactly in the EXEC cycle of a plain register write
        rf_we_n = cu_wr_en & ~cu_ldst_en & ~cu_done;
        state_n = EXEC;
      end
      EXEC: begin
        if (cu_done) begin
          halted_n = 1'b1;
          state_n  = HALT;
        end else if (cu_ldst_en) begin
          mem_req_n  = 1'b1;
          mem_we_n   = ~cu_wr_en;
          mem_addr_n = ldst_addr;
          state_n    = MEM;
        end else begin
          pc_n    = next_pc;
          state_n = FETCH;
        end
      end
      MEM: begin
        if (mem_ack) begin
          mem_req_n = 1'b0;
          mem_we_n  = 1'b0;
          if (mem_we) begin
            pc_n    = next_pc;
            state_n = FETCH;
          end else begin
            rf_we_n = 1'b1;
            state_n = WB;
          end
        end
      end
      WB: begin
        pc_n    = next_pc;
        state_n = FETCH;
      end
      HALT: begin
        mem_req_n = 1'b0;
      end
      default: state_n = FETCH;
    endcase
  end

endmodule

// File: tb/tb_cpu_sequencer.sv
// tb/tb_cpu_sequencer.sv - vector table, corner sequences and random instructions against a PC/latency model
module tb_cpu_sequencer;

  typedef struct {
    logic [1:0] fop;
    logic       wr;
    logic       ldst;
    logic       done;
    logic [9:0] jmp;
    logic       take;
    logic [9:0] tgt;
    logic [9:0] lda;
    logic [9:0] rdata;
    int         fw;
    int         mw;
  } ins_t;

  typedef struct {
    ins_t       i;
    logic [9:0] epc;
    int         erf;
    int         elat;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst;
  logic       mem_req, mem_ack, mem_we;
  logic [9:0] mem_addr, mem_rdata, ir;
  logic [1:0] cu_fetch_op;
  logic       cu_wr_en, cu_ldst_en, cu_done, branch_take;
  logic [9:0] jmp_addr, reg_target, ldst_addr;
  logic       rf_we, halted;
  logic [9:0] pc;
`ifdef CPU_SEQ_SINGLE_STEP_EN
  logic       step = 1'b1;
`endif

  int         ncmp = 0;
  int         nbad = 0;
  int         cyc  = 0;
  logic [9:0] cur_pc;
  vec_t       tbl[14];

  cpu_sequencer dut (
    .clk         (clk),
    .rst         (rst),
`ifdef CPU_SEQ_SINGLE_STEP_EN
    .step        (step),
`endif
    .mem_req     (mem_req),
    .mem_ack     (mem_ack),
    .mem_we      (mem_we),
    .mem_addr    (mem_addr),
    .mem_rdata   (mem_rdata),
    .ir          (ir),
    .cu_fetch_op (cu_fetch_op),
    .cu_wr_en    (cu_wr_en),
    .cu_ldst_en  (cu_ldst_en),
    .cu_done     (cu_done),
    .jmp_addr    (jmp_addr),
    .branch_take (branch_take),
    .reg_target  (reg_target),
    .ldst_addr   (ldst_addr),
    .rf_we       (rf_we),
    .pc          (pc),
    .halted      (halted)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    ncmp++;
    if (act !== exp) begin
      nbad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  function automatic logic [9:0] model_pc(input logic [9:0] p, input ins_t d);
    int base = int'(p);
    int off  = int'(d.jmp);
    if (off >= 512) off -= 1024;
    case (d.fop)
      2'd1:    return d.take ? 10'((base + off + 1024) % 1024) : 10'((base + 1) % 1024);
      2'd2:    return d.tgt;
      2'd3:    return p;
      default: return 10'((base + 1) % 1024);
    endcase
  endfunction

  function automatic int model_lat(input ins_t d);
    return d.fw + 4 + (d.ldst ? (d.mw + 1 + (d.wr ? 1 : 0)) : 0);
  endfunction

  function automatic int model_rf(input ins_t d);
    return (d.wr && !d.done) ? 1 : 0;
  endfunction

  function automatic vec_t mk(input logic [1:0] fop, input logic wr, input logic ldst,
                              input logic [9:0] jmp, input logic take, input logic [9:0] tgt,
                              input logic [9:0] lda, input int fw, input int mw,
                              input logic [9:0] epc, input int erf, input int elat);
    vec_t v;
    v.i.fop = fop;   v.i.wr = wr;     v.i.ldst = ldst; v.i.done = 1'b0;
    v.i.jmp = jmp;   v.i.take = take; v.i.tgt = tgt;   v.i.lda = lda;
    v.i.rdata = '0;  v.i.fw = fw;     v.i.mw = mw;
    v.epc = epc;     v.erf = erf;     v.elat = elat;
    return v;
  endfunction

  // Plays memory (ack after fw/mw wait cycles) and Control_Unit for one instruction, observing
  // at negedges until the following fetch request rises (or a quiet window after a halt).
  task automatic run_one(input ins_t d, input logic [9:0] epc, input int erf, input int elat,
                         input string nm);
    int         nreq, wcnt, rfc, bad, t0, t1, lim;
    logic       prev, rwe, dwe;
    logic [9:0] raddr, daddr;
    cu_fetch_op = d.fop; cu_wr_en = d.wr; cu_ldst_en = d.ldst; cu_done = d.done;
    jmp_addr = d.jmp; branch_take = d.take; reg_target = d.tgt; ldst_addr = d.lda;
    nreq = 0; wcnt = 0; rfc = 0; bad = 0; t0 = 0; t1 = -1;
    prev = 1'b0; rwe = 1'b0; dwe = 1'b0; raddr = '0; daddr = '0;
    lim = d.done ? d.fw + 26 : 200;
    for (int g = 0; g < lim; g++) begin
      if (g > 0) @(negedge clk);
      if (mem_req && !prev) begin
        nreq++; wcnt = 0; raddr = mem_addr; rwe = mem_we;
        if (nreq == 1) begin
          t0 = cyc;
          chk({nm, " fetch_addr"}, 32'(mem_addr), 32'(cur_pc));
          chk({nm, " fetch_we"}, 32'(mem_we), 32'd0);
        end else if (nreq == 2 && d.ldst && !d.done) begin
          daddr = mem_addr; dwe = mem_we;
        end else begin
          t1 = cyc;
          break;
        end
      end
      if (mem_req && (mem_addr !== raddr || mem_we !== rwe)) bad++;
      if (rf_we) rfc++;
      if (mem_req && wcnt >= (nreq == 1 ? d.fw : d.mw)) begin
        mem_ack   = 1'b1;
        mem_rdata = (nreq == 1) ? d.rdata : 10'($urandom);
      end else begin
        mem_ack = 1'b0;
        if (mem_req) wcnt++;
      end
      prev = mem_req;
    end
    mem_ack = 1'b0;
    chk({nm, " ir"}, 32'(ir), 32'(d.rdata));
    chk({nm, " pc"}, 32'(pc), 32'(epc));
    chk({nm, " rf_we_pulses"}, 32'(rfc), 32'(erf));
    chk({nm, " addr_we_stable"}, 32'(bad), 32'd0);
    chk({nm, " halted"}, 32'(halted), 32'(d.done));
    if (d.done) chk({nm, " reqs_after_halt"}, 32'(nreq), 32'd1);
    else        chk({nm, " latency"}, 32'(t1 - t0), 32'(elat));
    if (d.ldst && !d.done) begin
      chk({nm, " data_addr"}, 32'(daddr), 32'(d.lda));
      chk({nm, " data_we"}, 32'(dwe), 32'(!d.wr));
    end
    cur_pc = epc;
  endtask

  initial begin
    ins_t d;
    rst = 1'b1; mem_ack = 1'b0; mem_rdata = '0;
    cu_fetch_op = '0; cu_wr_en = 1'b0; cu_ldst_en = 1'b0; cu_done = 1'b0;
    jmp_addr = '0; branch_take = 1'b0; reg_target = '0; ldst_addr = '0;
    cur_pc = 10'd0;

    //        fop   wr    ldst  jmp      take  tgt      lda      fw mw  epc      rf lat
    tbl[0]  = mk(2'd2, 1'b0, 1'b0, 10'h000, 1'b0, 10'h005, 10'h000, 0, 0, 10'h005, 0, 4);
    tbl[1]  = mk(2'd0, 1'b1, 1'b0, 10'h000, 1'b0, 10'h000, 10'h000, 0, 0, 10'h006, 1, 4);
    tbl[2]  = mk(2'd2, 1'b0, 1'b0, 10'h000, 1'b0, 10'h007, 10'h000, 1, 0, 10'h007, 0, 5);
    tbl[3]  = mk(2'd0, 1'b1, 1'b1, 10'h000, 1'b0, 10'h000, 10'h3F0, 0, 2, 10'h008, 1, 8);
    tbl[4]  = mk(2'd0, 1'b0, 1'b1, 10'h000, 1'b0, 10'h000, 10'h02A, 0, 1, 10'h009, 0, 6);
    tbl[5]  = mk(2'd0, 1'b1, 1'b1, 10'h000, 1'b0, 10'h000, 10'h001, 0, 0, 10'h00A, 1, 6);
    tbl[6]  = mk(2'd2, 1'b0, 1'b0, 10'h000, 1'b0, 10'h002, 10'h000, 0, 0, 10'h002, 0, 4);
    tbl[7]  = mk(2'd1, 1'b0, 1'b0, 10'h3FE, 1'b1, 10'h000, 10'h000, 0, 0, 10'h000, 0, 4);
    tbl[8]  = mk(2'd2, 1'b0, 1'b0, 10'h000, 1'b0, 10'h002, 10'h000, 0, 0, 10'h002, 0, 4);
    tbl[9]  = mk(2'd1, 1'b0, 1'b0, 10'h3FE, 1'b0, 10'h000, 10'h000, 0, 0, 10'h003, 0, 4);
    tbl[10] = mk(2'd2, 1'b0, 1'b0, 10'h000, 1'b0, 10'h3FF, 10'h000, 3, 0, 10'h3FF, 0, 7);
    tbl[11] = mk(2'd0, 1'b1, 1'b0, 10'h000, 1'b0, 10'h000, 10'h000, 0, 0, 10'h000, 1, 4);
    tbl[12] = mk(2'd1, 1'b0, 1'b0, 10'h3FF, 1'b1, 10'h000, 10'h000, 0, 0, 10'h3FF, 0, 4);
    tbl[13] = mk(2'd2, 1'b1, 1'b0, 10'h000, 1'b0, 10'h009, 10'h000, 0, 0, 10'h009, 1, 4);

    repeat (2) @(negedge clk);
    chk("reset pc", 32'(pc), 32'd0);
    chk("reset ir", 32'(ir), 32'd0);
    chk("reset mem_req", 32'(mem_req), 32'd0);
    chk("reset mem_we", 32'(mem_we), 32'd0);
    chk("reset mem_addr", 32'(mem_addr), 32'd0);
    chk("reset rf_we", 32'(rf_we), 32'd0);
    chk("reset halted", 32'(halted), 32'd0);
    rst = 1'b0;
    @(negedge clk);

    for (int k = 0; k < 14; k++) begin
      tbl[k].i.rdata = 10'(k * 37 + 1);
      run_one(tbl[k].i, tbl[k].epc, tbl[k].erf, tbl[k].elat, $sformatf("vec%0d", k));
    end

    // halt at pc 9: pc frozen, no further requests
    d = tbl[0].i;
    d.fop = 2'd3; d.wr = 1'b0; d.ldst = 1'b0; d.done = 1'b1; d.rdata = 10'h1E1;
    run_one(d, 10'h009, 0, 0, "halt");

    #2 rst = 1'b1;
    #1 chk("rst clears halted", 32'(halted), 32'd0);
    chk("rst loads pc", 32'(pc), 32'd0);
    @(negedge clk) rst = 1'b0;
    @(negedge clk);
    cur_pc = 10'd0;
    d = tbl[0].i; d.tgt = 10'h155; d.rdata = 10'h0F0;
    run_one(d, 10'h155, 0, 4, "jr155");

    // reset while the fetch at 0x155 is pending, with an ack landing during and after reset
    #2 rst = 1'b1; mem_ack = 1'b1; mem_rdata = 10'h3C3;
    #1 chk("rst drops mem_req", 32'(mem_req), 32'd0);
    chk("rst pc mid-fetch", 32'(pc), 32'd0);
    @(negedge clk) rst = 1'b0;
    @(negedge clk);
    chk("stale ack ir", 32'(ir), 32'd0);
    chk("refetch req", 32'(mem_req), 32'd1);
    cur_pc = 10'd0;
    d = tbl[1].i; d.rdata = 10'h2B4;
    run_one(d, 10'h001, 1, 4, "after_rst");

    for (int i = 0; i < 40; i++) begin
      d.fop = 2'($urandom_range(0, 3));
      d.wr = 1'($urandom_range(0, 1));
      d.ldst = 1'($urandom_range(0, 1));
      d.done = 1'b0;
      d.jmp = 10'($urandom);
      d.take = 1'($urandom_range(0, 1));
      d.tgt = 10'($urandom);
      d.lda = 10'($urandom);
      d.rdata = 10'($urandom);
      d.fw = int'($urandom_range(0, 3));
      d.mw = int'($urandom_range(0, 3));
      run_one(d, model_pc(cur_pc, d), model_rf(d), model_lat(d), $sformatf("rnd%0d", i));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nbad);
    $finish;
  end

endmodule
